// File: rtl/quad_decoder_if.sv
// Signal bundle between a quadrature source/consumer and quad_decoder.
// The master drives the encoder pins and clear; the slave (decoder) returns the step and position outputs.
interface quad_decoder_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 a_in;
    logic                 b_in;
    logic                 clr;
    logic                 step_cw;
    logic                 step_ccw;
    logic                 err;
    logic                 dir;
    logic [CNT_WIDTH-1:0] position;
    logic [7:0]           err_cnt;

    modport master (
        output a_in, b_in, clr,
        input  step_cw, step_ccw, err, dir, position, err_cnt
    );

    modport slave (
        input  a_in, b_in, clr,
        output step_cw, step_ccw, err, dir, position, err_cnt
    );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronises and glitch-filters A/B, decodes Gray steps
// into cw/ccw/err pulses, and keeps a wrapping position and saturating error count.
module quad_decoder #(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    quad_decoder_if.slave bus
);

    typedef enum logic {ST_INIT, ST_TRACK} state_e;

    // INIT waits until every sync and filter flop holds a post-reset sample,
    // so the reset-cleared 00 history is never mistaken for a real input.
    localparam int PRIME_LEN = SYNC_STAGES + FILTER_LEN;
    localparam int PRIME_W   = $clog2(PRIME_LEN + 1);

    logic [1:0]           sync_q [SYNC_STAGES];
    logic [1:0]           hist_q [FILTER_LEN];
    logic [1:0]           s_ab;
    logic [1:0]           cand;
    logic                 cand_valid;

    state_e               state_q;
    logic [PRIME_W-1:0]   prime_q;
    logic [1:0]           fab_q;
    logic                 step_cw_q;
    logic                 step_ccw_q;
    logic                 err_q;
    logic                 dir_q;
    logic [CNT_WIDTH-1:0] position_q;
    logic [7:0]           err_cnt_q;

    // Gray successors, codes written {A,B}: cw order 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] cw_succ(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] ccw_succ(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    assign s_ab = sync_q[SYNC_STAGES-1];

    // NOTE: these small shift registers are reset because a mid-operation reset
    // must discard partial history; this is flop storage, not a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b00;
            for (int i = 0; i < FILTER_LEN; i++)  hist_q[i] <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments make every stage read the old value
            // of its neighbour, which is what turns the loops into shift registers.
            sync_q[0] <= {bus.a_in, bus.b_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            hist_q[0] <= s_ab;
            for (int i = 1; i < FILTER_LEN; i++)  hist_q[i] <= hist_q[i-1];
        end
    end

    // NOTE: cand_valid gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        cand       = hist_q[0];
        cand_valid = 1'b1;
        for (int i = 1; i < FILTER_LEN; i++) begin
            if (hist_q[i] != hist_q[0]) cand_valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            prime_q    <= '0;
            fab_q      <= 2'b00;
            step_cw_q  <= 1'b0;
            step_ccw_q <= 1'b0;
            err_q      <= 1'b0;
            dir_q      <= 1'b0;
            position_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            step_cw_q  <= 1'b0;
            step_ccw_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    if (prime_q != PRIME_W'(PRIME_LEN)) begin
                        prime_q <= prime_q + PRIME_W'(1);
                    end else if (cand_valid) begin
                        fab_q   <= cand;
                        state_q <= ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (cand_valid && cand != fab_q) begin
                        fab_q <= cand;
                        if (cand == cw_succ(fab_q)) begin
                            step_cw_q  <= 1'b1;
                            dir_q      <= 1'b1;
                            position_q <= position_q + CNT_WIDTH'(1);
                        end else if (cand == ccw_succ(fab_q)) begin
                            step_ccw_q <= 1'b1;
                            dir_q      <= 1'b0;
                            position_q <= position_q - CNT_WIDTH'(1);
                        end else begin
                            err_q <= 1'b1;
                            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_q <= ST_INIT;
            endcase
            // Placed last so a coincident step still pulses but the counters read zero.
            if (bus.clr) begin
                position_q <= '0;
                err_cnt_q  <= '0;
            end
        end
    end

    assign bus.step_cw  = step_cw_q;
    assign bus.step_ccw = step_ccw_q;
    assign bus.err      = err_q;
    assign bus.dir      = dir_q;
    assign bus.position = position_q;
    assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed table, hand-written corner
// sequences, then randomized segments against a Gray-index reference model.
module tb_quad_decoder;

    localparam int CW   = 16;
    localparam int SYNC = 2;
    localparam int FILT = 3;
    localparam int LAT  = SYNC + FILT + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    quad_decoder_if #(.CNT_WIDTH(CW)) bus ();

    quad_decoder #(
        .CNT_WIDTH   (CW),
        .SYNC_STAGES (SYNC),
        .FILTER_LEN  (FILT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Pulse monitor, sampled on the falling edge.
    int cnt_cw = 0, cnt_ccw = 0, cnt_err = 0, n_overlap = 0;
    always @(negedge clk) begin
        if (bus.step_cw)  cnt_cw  <= cnt_cw + 1;
        if (bus.step_ccw) cnt_ccw <= cnt_ccw + 1;
        if (bus.err)      cnt_err <= cnt_err + 1;
        if (int'(bus.step_cw) + int'(bus.step_ccw) + int'(bus.err) > 1) n_overlap <= n_overlap + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  ab;
        bit          clr;
        int          exp_cw;
        int          exp_ccw;
        int          exp_err;
        logic [15:0] exp_pos;
        bit          exp_dir;
        logic [7:0]  exp_ec;
    } vec_t;

    vec_t tbl[12];

    // Reference model state: last accepted code, counters.
    logic [1:0]  m_ab;
    logic [15:0] m_pos;
    bit          m_dir;
    logic [7:0]  m_ec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] ab, input bit c);
        bus.a_in = ab[1];
        bus.b_in = ab[0];
        bus.clr  = c;
    endtask

    function automatic logic pulse(input int which);
        case (which)
            0:       return bus.step_cw;
            1:       return bus.step_ccw;
            default: return bus.err;
        endcase
    endfunction

    // Position of a code along the cw cycle (Gray to binary, b is the MSB).
    function automatic int gidx(input logic [1:0] v);
        return 2 * int'(v[0]) + int'(v[1] ^ v[0]);
    endfunction

    task automatic run_seg(input logic [1:0] ab, input bit c, input int hold,
                           output int dcw, output int dccw, output int derr);
        int s_cw, s_ccw, s_err;
        s_cw = cnt_cw; s_ccw = cnt_ccw; s_err = cnt_err;
        drive(ab, c);
        tick(1);
        bus.clr = 1'b0;
        tick(hold - 1);
        dcw  = cnt_cw  - s_cw;
        dccw = cnt_ccw - s_ccw;
        derr = cnt_err - s_err;
    endtask

    task automatic check_outputs(input string tag, input int dcw, input int dccw, input int derr,
                                 input int ecw, input int eccw, input int eerr,
                                 input logic [15:0] epos, input bit edir, input logic [7:0] eec);
        check({tag, " cw"},  dcw,  ecw);
        check({tag, " ccw"}, dccw, eccw);
        check({tag, " err"}, derr, eerr);
        check({tag, " pos"}, bus.position, epos);
        check({tag, " dir"}, bus.dir, edir);
        check({tag, " err_cnt"}, bus.err_cnt, eec);
    endtask

    task automatic model_seg(input logic [1:0] ab, input bit c, input bit glitch, input int hold,
                             input string tag);
        logic [1:0] g;
        int d, ecw, eccw, eerr, dcw, dccw, derr;
        ecw = 0; eccw = 0; eerr = 0;
        if (glitch) begin
            g = m_ab ^ 2'($urandom_range(1, 3));
            drive(g, 1'b0);
            tick($urandom_range(1, FILT - 1));
            drive(m_ab, 1'b0);
            tick(FILT);
        end
        if (c) begin
            m_pos = '0;
            m_ec  = '0;
        end
        if (ab != m_ab) begin
            d = (gidx(ab) - gidx(m_ab) + 4) % 4;
            if (d == 1) begin
                ecw = 1; m_pos = m_pos + 16'd1; m_dir = 1'b1;
            end else if (d == 3) begin
                eccw = 1; m_pos = m_pos - 16'd1; m_dir = 1'b0;
            end else begin
                eerr = 1;
                if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
            end
        end
        m_ab = ab;
        run_seg(ab, c, hold, dcw, dccw, derr);
        check_outputs(tag, dcw, dccw, derr, ecw, eccw, eerr, m_pos, m_dir, m_ec);
    endtask

    task automatic measure(input int which, input string name);
        int lat;
        lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            tick(1);
            if (pulse(which)) lat = k;
        end
        check({name, " latency"}, lat, LAT);
        tick(1);
        check({name, " width"}, pulse(which), 1'b0);
    endtask

    initial begin
        int dcw, dccw, derr, s_cw, s_ccw, s_err;

        // Directed table: each row held 10 cycles; clr asserted on its first cycle.
        tbl[0]  = '{2'b10, 1'b0, 1, 0, 0, 16'h0001, 1'b1, 8'd0};
        tbl[1]  = '{2'b11, 1'b0, 1, 0, 0, 16'h0002, 1'b1, 8'd0};
        tbl[2]  = '{2'b01, 1'b0, 1, 0, 0, 16'h0003, 1'b1, 8'd0};
        tbl[3]  = '{2'b00, 1'b0, 1, 0, 0, 16'h0004, 1'b1, 8'd0};
        tbl[4]  = '{2'b00, 1'b1, 0, 0, 0, 16'h0000, 1'b1, 8'd0};
        tbl[5]  = '{2'b01, 1'b0, 0, 1, 0, 16'hFFFF, 1'b0, 8'd0};
        tbl[6]  = '{2'b00, 1'b0, 1, 0, 0, 16'h0000, 1'b1, 8'd0};
        tbl[7]  = '{2'b11, 1'b0, 0, 0, 1, 16'h0000, 1'b1, 8'd1};
        tbl[8]  = '{2'b01, 1'b0, 1, 0, 0, 16'h0001, 1'b1, 8'd1};
        tbl[9]  = '{2'b10, 1'b0, 0, 0, 1, 16'h0001, 1'b1, 8'd2};
        tbl[10] = '{2'b00, 1'b0, 0, 1, 0, 16'h0000, 1'b0, 8'd2};
        tbl[11] = '{2'b00, 1'b1, 0, 0, 0, 16'h0000, 1'b0, 8'd0};

        // Reset with inputs at 00; INIT must adopt 00 silently.
        rst_n = 1'b0;
        drive(2'b00, 1'b0);
        tick(3);
        check("reset pos", bus.position, 16'h0000);
        check("reset err_cnt", bus.err_cnt, 8'h00);
        check("reset pulses", {bus.step_cw, bus.step_ccw, bus.err, bus.dir}, 4'b0000);
        rst_n = 1'b1;
        s_cw = cnt_cw; s_ccw = cnt_ccw; s_err = cnt_err;
        tick(10);
        check_outputs("init", cnt_cw - s_cw, cnt_ccw - s_ccw, cnt_err - s_err,
                      0, 0, 0, 16'h0000, 1'b0, 8'd0);

        for (int i = 0; i < 12; i++) begin
            run_seg(tbl[i].ab, tbl[i].clr, 10, dcw, dccw, derr);
            check_outputs($sformatf("row%0d", i), dcw, dccw, derr,
                          tbl[i].exp_cw, tbl[i].exp_ccw, tbl[i].exp_err,
                          tbl[i].exp_pos, tbl[i].exp_dir, tbl[i].exp_ec);
        end

        // Exact latency and one-cycle width of a cw and a ccw step.
        drive(2'b10, 1'b0);
        measure(0, "cw step");
        tick(3);
        check("after cw pos", bus.position, 16'h0001);
        drive(2'b00, 1'b0);
        measure(1, "ccw step");
        tick(3);
        check("after ccw pos", bus.position, 16'h0000);
        check("after ccw dir", bus.dir, 1'b0);

        // A-channel glitch of 2 cycles must vanish.
        s_cw = cnt_cw; s_ccw = cnt_ccw; s_err = cnt_err;
        drive(2'b10, 1'b0);
        tick(2);
        drive(2'b00, 1'b0);
        tick(12);
        check_outputs("glitch", cnt_cw - s_cw, cnt_ccw - s_ccw, cnt_err - s_err,
                      0, 0, 0, 16'h0000, 1'b0, 8'd0);

        // clr on the very edge that accepts a cw step.
        run_seg(2'b10, 1'b0, 10, dcw, dccw, derr);
        check("pre-clr pos", bus.position, 16'h0001);
        drive(2'b11, 1'b0);
        tick(LAT - 1);
        bus.clr = 1'b1;
        tick(1);
        bus.clr = 1'b0;
        check("clr+step pulse", bus.step_cw, 1'b1);
        check("clr+step pos", bus.position, 16'h0000);
        check("clr+step dir", bus.dir, 1'b1);
        tick(5);
        check("clr+step pos later", bus.position, 16'h0000);

        // Reset in the middle of filtering, inputs sitting at 11.
        drive(2'b00, 1'b0);
        tick(3);
        drive(2'b11, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midreset outs", {bus.step_cw, bus.step_ccw, bus.err, bus.dir}, 4'b0000);
        check("midreset pos", bus.position, 16'h0000);
        tick(3);
        rst_n = 1'b1;
        s_cw = cnt_cw; s_ccw = cnt_ccw; s_err = cnt_err;
        tick(20);
        check_outputs("post-reset", cnt_cw - s_cw, cnt_ccw - s_ccw, cnt_err - s_err,
                      0, 0, 0, 16'h0000, 1'b0, 8'd0);

        // From here the reference model drives the expectations.
        m_ab = 2'b11; m_pos = '0; m_dir = 1'b0; m_ec = '0;
        model_seg(2'b01, 1'b0, 1'b0, 10, "adopt11");

        for (int i = 0; i < 60; i++) begin
            model_seg(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 3) == 0), $urandom_range(8, 12),
                      $sformatf("rnd%0d", i));
        end

        // Drive err_cnt into saturation with repeated double-bit flips.
        for (int i = 0; i < 260; i++) begin
            model_seg(m_ab ^ 2'b11, 1'b0, 1'b0, 8, $sformatf("sat%0d", i));
        end
        check("saturated err_cnt", bus.err_cnt, 8'hFF);
        check("pulse exclusivity", n_overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
